// File: rtl/irq_controller_if.sv
// Data-memory bus between the core and the interrupt controller's register window.
interface irq_controller_if;
    logic [31:0] memaddr;
    logic        memwrite;
    logic        memread;
    logic [31:0] writedata;
    logic [3:0]  be;
    logic        sel;
    logic [31:0] readdata;

    modport master (
        output memaddr, memwrite, memread, writedata, be,
        input  sel, readdata
    );

    modport slave (
        input  memaddr, memwrite, memread, writedata, be,
        output sel, readdata
    );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronises, latches and masks NUM_SRC
// interrupt lines and drives the core's registered active-low nIRQ.
module irq_controller #(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_controller_if.slave    bus,
    output logic               nIRQ,
    output logic [4:0]         irq_id
);

    localparam logic [3:0] REG_RAW     = 4'd0;
    localparam logic [3:0] REG_ENABLE  = 4'd1;
    localparam logic [3:0] REG_PENDING = 4'd2;
    localparam logic [3:0] REG_EDGE    = 4'd3;
    localparam logic [3:0] REG_CLAIM   = 4'd4;

    logic [NUM_SRC-1:0] sync1, sync2, sync2_d;
    logic [NUM_SRC-1:0] enable, pending, edge_mode;
    logic [NUM_SRC-1:0] wmask, wdata, w1c, rise, active;
    logic [31:0]        byte_mask;
    logic [31:0]        reg_data;
    logic [3:0]         word;
    logic               wr_en;
    logic               unused_bits;

    assign bus.sel = (bus.memaddr & ~32'h3F) == BASE_ADDR;
    assign word    = bus.memaddr[5:2];
    assign wr_en   = bus.memwrite && bus.sel;

    always_comb begin
        byte_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{bus.be[i]}};
        end
    end

    assign wmask  = byte_mask[NUM_SRC-1:0];
    assign wdata  = bus.writedata[NUM_SRC-1:0];
    assign w1c    = (wr_en && word == REG_PENDING) ? (wdata & wmask) : '0;
    assign rise   = sync2 & ~sync2_d;
    assign active = pending & enable;

    // Register bits above NUM_SRC and the byte offset are deliberately dropped.
    assign unused_bits = ^{bus.memaddr[1:0], byte_mask, bus.writedata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync2_d   <= '0;
            enable    <= '0;
            pending   <= '0;
            edge_mode <= '0;
            nIRQ      <= 1'b1;
        end else begin
            sync1   <= irq_src;
            sync2   <= sync1;
            sync2_d <= sync2;
            // Edge bits: rise is OR-ed after the clear so a same-edge rise wins.
            pending <= (edge_mode & ((pending & ~w1c) | rise)) | (~edge_mode & sync2);
            if (wr_en && word == REG_ENABLE) begin
                enable <= (enable & ~wmask) | (wdata & wmask);
            end
            if (wr_en && word == REG_EDGE) begin
                edge_mode <= (edge_mode & ~wmask) | (wdata & wmask);
            end
            nIRQ <= ~|active;
        end
    end

    always_comb begin
        irq_id = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (active[i-1]) begin
                irq_id = 5'(i - 1);
            end
        end
    end

    always_comb begin
        reg_data = '0;
        case (word)
            REG_RAW:     reg_data[NUM_SRC-1:0] = sync2;
            REG_ENABLE:  reg_data[NUM_SRC-1:0] = enable;
            REG_PENDING: reg_data[NUM_SRC-1:0] = pending;
            REG_EDGE:    reg_data[NUM_SRC-1:0] = edge_mode;
            REG_CLAIM:   reg_data = {|active, 26'b0, irq_id};
            default:     reg_data = '0;
        endcase
        bus.readdata = (bus.sel && bus.memread) ? reg_data : '0;
    end

endmodule
